imm_load_sequencer: RTL and testbench
=====================================

// Module: imm_load_sequencer
// PURPOSE
//  Builds an arbitrary 64-bit constant in a register by emitting a short sequence of
//  MOVZ/MOVK instruction words. The words feed the instruction path, and the immediate
//  extender (IW mode) expands each one: imm16 = bits[20:5], shift = 16*bits[22:21].
//  Used by the boot/test loader and pseudo-op expansion; sits upstream of decode.
// PARAMETERS
//  SKIP_ZERO  1  1: emit only non-zero halfwords; 0: always emit all four halfwords
// PORTS
//  CLK         in   1   clock, rising edge
//  Reset       in   1   asynchronous, active-high reset
//  ReqValid    in   1   constant-load request valid
//  ReqReady    out  1   sequencer can accept a request (IDLE)
//  ReqValue    in   64  constant to materialise
//  ReqRd       in   5   destination register (31 = XZR, passed through unchanged)
//  InstrValid  out  1   Instr holds a valid word
//  InstrReady  in   1   consumer accepts Instr this cycle
//  Instr       out  32  MOVZ/MOVK word
//  Done        out  1   one-cycle pulse after the last word is accepted
//  NumIssued   out  3   number of words in the last completed sequence (1..4)
//  Busy        out  1   sequence in progress (EMIT state)
// BEHAVIOUR
//  Reset: state=IDLE; ReqReady=1, InstrValid=0, Instr=0, Done=0, NumIssued=0, Busy=0.
//  FSM states: IDLE, EMIT.
//  - IDLE: ReqReady=1. On ReqValid&ReqReady, register ReqValue/ReqRd, build a 4-bit
//    halfword mask, and go to EMIT. InstrValid=1 from the next cycle (1-cycle latency).
//  - EMIT: ReqReady=0, Busy=1. ReqValid is ignored.
//  Mask rules:
//  - SKIP_ZERO=1: mask bit h = (ReqValue[16h+15:16h] != 0). An all-zero mask becomes 4'b0001.
//  - SKIP_ZERO=0: mask = 4'b1111.
//  Emission order: ascending hw over the set mask bits.
//  - First word is MOVZ: Instr = {9'b110100101, hw[1:0], imm16, Rd}.
//  - Every later word is MOVK: Instr = {9'b111100101, hw[1:0], imm16, Rd}.
//  - imm16 = captured value[16hw+15:16hw].
//  Handshake:
//  - A word transfers when InstrValid & InstrReady.
//  - While InstrValid & !InstrReady, Instr must stay stable.
//  - After a transfer, the next word is presented on the following cycle (no bubble).
//  Completion:
//  - The cycle the last word transfers, the next state is IDLE.
//  - In that next cycle, Done=1 for exactly one cycle and NumIssued = words emitted.
//  - NumIssued holds until the next completion.
//  - A new request may be accepted in the same cycle Done=1.
//  Outputs are registered. Instr returns to 0 and InstrValid=0 in IDLE.
//  Reset mid-sequence:
//  - Asserting Reset aborts immediately; the partial sequence is abandoned.
//  - No Done is issued; NumIssued=0.
//  Internal halfword index: 2 bits. The word count saturates naturally at 4.
// TESTING
//  1. Value 0x0000_0000_0000_1234, Rd=3 -> one word 0xD2824683; Done=1, NumIssued=1.
//  2. Value 0x1234_0000_5678_0000, Rd=1 -> 0xD2AACF01 then 0xF2E24681; NumIssued=2.
//  3. Value 0, Rd=0 -> single word 0xD2800000; NumIssued=1.
//  4. Value all-ones, Rd=2, InstrReady low 5 cycles on the first word -> 0xD29FFFE2 held
//     stable throughout, then 0xF2BFFFE2, 0xF2DFFFE2, 0xF2FFFFE2; NumIssued=4.
//  5. Reset asserted after the 2nd of 4 words -> all outputs 0 and no Done;
//     ReqReady=1 after reset release.
//  6. ReqValid held during EMIT is ignored. A back-to-back request in the Done cycle is
//     accepted, and its first word appears on the next cycle.
//  7. SKIP_ZERO=0, value 0x5 -> 0xD28000A0 plus MOVK hw1..3 with imm16=0; NumIssued=4.

Source files
------------

// File: rtl/imm_load_sequencer.sv
// Expands a 64-bit constant into a MOVZ/MOVK instruction stream (one word per halfword),
// with a valid/ready output handshake and a one-cycle Done pulse on completion.
module imm_load_sequencer #(
  parameter int SKIP_ZERO = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [63:0] ReqValue,
  input  logic [4:0]  ReqRd,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic        Done,
  output logic [2:0]  NumIssued,
  output logic        Busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_n;
  logic [63:0] val, val_n;
  logic [4:0]  rd, rd_n;
  logic [3:0]  mask, mask_n;
  logic [1:0]  hw, hw_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] instr_n;
  logic        valid_n, done_n;
  logic [2:0]  num_n;
  logic [3:0]  req_mask, above;

  function automatic logic [3:0] build_mask(input logic [63:0] v);
    logic [3:0] m;
    m = 4'b1111;
    if (SKIP_ZERO != 0) begin
      for (int h = 0; h < 4; h++) m[h] = |v[16*h +: 16];
      if (m == 4'b0000) m = 4'b0001;
    end
    return m;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int h = 3; h >= 0; h--) if (m[h]) r = 2'(h);
    return r;
  endfunction

  function automatic logic [31:0] word(input logic movk, input logic [1:0] h,
                                       input logic [63:0] v, input logic [4:0] r);
    return {(movk ? 9'b111100101 : 9'b110100101), h, v[{h, 4'b0000} +: 16], r};
  endfunction

  assign ReqReady = (state == IDLE);
  assign Busy     = (state == EMIT);
  assign req_mask = build_mask(ReqValue);
  // Mask bits strictly above the halfword currently on the output.
  assign above    = mask & (4'b1110 << hw);

  always_comb begin
    state_n = state;
    val_n   = val;
    rd_n    = rd;
    mask_n  = mask;
    hw_n    = hw;
    cnt_n   = cnt;
    instr_n = Instr;
    valid_n = InstrValid;
    done_n  = 1'b0;
    num_n   = NumIssued;
    case (state)
      IDLE: begin
        instr_n = 32'd0;
        valid_n = 1'b0;
        if (ReqValid) begin
          state_n = EMIT;
          val_n   = ReqValue;
          rd_n    = ReqRd;
          mask_n  = req_mask;
          hw_n    = lowest(req_mask);
          cnt_n   = 3'd0;
          instr_n = word(1'b0, lowest(req_mask), ReqValue, ReqRd);
          valid_n = 1'b1;
        end
      end
      EMIT: begin
        if (InstrReady) begin
          cnt_n = cnt + 3'd1;
          if (above == 4'b0000) begin
            state_n = IDLE;
            instr_n = 32'd0;
            valid_n = 1'b0;
            done_n  = 1'b1;
            num_n   = cnt + 3'd1;
          end else begin
            hw_n    = lowest(above);
            instr_n = word(1'b1, lowest(above), val, rd);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      val        <= '0;
      rd         <= '0;
      mask       <= '0;
      hw         <= '0;
      cnt        <= '0;
      Instr      <= '0;
      InstrValid <= 1'b0;
      Done       <= 1'b0;
      NumIssued  <= '0;
    end else begin
      state      <= state_n;
      val        <= val_n;
      rd         <= rd_n;
      mask       <= mask_n;
      hw         <= hw_n;
      cnt        <= cnt_n;
      Instr      <= instr_n;
      InstrValid <= valid_n;
      Done       <= done_n;
      NumIssued  <= num_n;
    end
  end

endmodule

// File: tb/tb_imm_load_sequencer.sv
// Directed bench for imm_load_sequencer: table-driven sequences on a SKIP_ZERO=1 and a
// SKIP_ZERO=0 instance, plus hand-written stall, reset-abort and back-to-back cases.
module tb_imm_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic [63:0] req_value = '0;
  logic [4:0]  req_rd = '0;
  logic        instr_ready = 1'b0;
  logic        sel = 1'b0;

  logic        req_ready0, req_ready1, instr_valid0, instr_valid1;
  logic [31:0] instr0, instr1;
  logic        done0, done1, busy0, busy1;
  logic [2:0]  num0, num1;

  logic        o_ready, o_valid, o_done, o_busy;
  logic [31:0] o_instr;
  logic [2:0]  o_num;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_load_sequencer #(.SKIP_ZERO(1)) dut0 (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid0), .ReqReady(req_ready0),
    .ReqValue(req_value), .ReqRd(req_rd), .InstrValid(instr_valid0),
    .InstrReady(instr_ready), .Instr(instr0), .Done(done0), .NumIssued(num0), .Busy(busy0));

  imm_load_sequencer #(.SKIP_ZERO(0)) dut1 (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid1), .ReqReady(req_ready1),
    .ReqValue(req_value), .ReqRd(req_rd), .InstrValid(instr_valid1),
    .InstrReady(instr_ready), .Instr(instr1), .Done(done1), .NumIssued(num1), .Busy(busy1));

  assign o_ready = sel ? req_ready1   : req_ready0;
  assign o_valid = sel ? instr_valid1 : instr_valid0;
  assign o_instr = sel ? instr1       : instr0;
  assign o_done  = sel ? done1        : done0;
  assign o_num   = sel ? num1         : num0;
  assign o_busy  = sel ? busy1        : busy0;

  typedef struct {
    logic             skip0;
    logic [63:0]      value;
    logic [4:0]       rd;
    int               n;
    logic [3:0][31:0] w;
    int               stall;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic v);
    if (sel) req_valid1 = v; else req_valid0 = v;
  endtask

  task automatic run(input vec_t t);
    sel = t.skip0;
    @(negedge clk);
    chk("ready_before_req", 64'(o_ready), 64'd1);
    req_value = t.value;
    req_rd    = t.rd;
    set_req(1'b1);
    @(negedge clk);
    set_req(1'b0);
    for (int k = 0; k < t.n; k++) begin
      for (int s = 0; s < ((k == 0) ? t.stall : 0); s++) begin
        instr_ready = 1'b0;
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_instr", 64'(o_instr), 64'(t.w[k]));
        @(negedge clk);
      end
      instr_ready = 1'b1;
      chk("word_valid", 64'(o_valid), 64'd1);
      chk("word_instr", 64'(o_instr), 64'(t.w[k]));
      chk("busy", 64'(o_busy), 64'd1);
      chk("ready_in_emit", 64'(o_ready), 64'd0);
      @(negedge clk);
    end
    instr_ready = 1'b0;
    chk("done_pulse", 64'(o_done), 64'd1);
    chk("num_issued", 64'(o_num), 64'(t.n));
    chk("idle_valid", 64'(o_valid), 64'd0);
    chk("idle_instr", 64'(o_instr), 64'd0);
    chk("idle_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("num_hold", 64'(o_num), 64'(t.n));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 64'h0000_0000_0000_1234, 5'd3, 1,
                {32'h0, 32'h0, 32'h0, 32'hD2824683}, 0};
    vecs[1] = '{1'b0, 64'h1234_0000_5678_0000, 5'd1, 2,
                {32'h0, 32'h0, 32'hF2E24681, 32'hD2AACF01}, 0};
    vecs[2] = '{1'b0, 64'h0, 5'd0, 1,
                {32'h0, 32'h0, 32'h0, 32'hD2800000}, 0};
    vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 4,
                {32'hF2FFFFE2, 32'hF2DFFFE2, 32'hF2BFFFE2, 32'hD29FFFE2}, 5};
    vecs[4] = '{1'b0, 64'h8000_0000_0000_0000, 5'd31, 1,
                {32'h0, 32'h0, 32'h0, 32'hD2F0001F}, 0};
    vecs[5] = '{1'b0, 64'h0001_0000_0000_0001, 5'd5, 2,
                {32'h0, 32'h0, 32'hF2E00025, 32'hD2800025}, 1};
    vecs[6] = '{1'b1, 64'h5, 5'd0, 4,
                {32'hF2E00000, 32'hF2C00000, 32'hF2A00000, 32'hD28000A0}, 0};

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(req_ready0), 64'd1);
    chk("rst_valid", 64'(instr_valid0), 64'd0);
    chk("rst_instr", 64'(instr0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_num", 64'(num0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Reset aborts a 4-word sequence after two words have transferred
    sel = 1'b0;
    @(negedge clk);
    req_value = 64'hFFFF_FFFF_FFFF_FFFF;
    req_rd = 5'd2;
    req_valid0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("abort_word2", 64'(instr0), 64'hF2BFFFE2);
    @(negedge clk);
    instr_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_valid", 64'(instr_valid0), 64'd0);
    chk("abort_instr", 64'(instr0), 64'd0);
    chk("abort_num", 64'(num0), 64'd0);
    chk("abort_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready0), 64'd1);
      chk("post_rst_done", 64'(done0), 64'd0);
      chk("post_rst_valid", 64'(instr_valid0), 64'd0);
    end

    // ReqValid held through EMIT is ignored; then taken in the Done cycle
    req_value = 64'h0000_0000_0000_1234;
    req_rd = 5'd3;
    req_valid0 = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    req_value = 64'h0000_0000_ABCD_0000;
    req_rd = 5'd7;
    chk("b2b_first", 64'(instr0), 64'hD2824683);
    @(negedge clk);
    chk("b2b_ignored_instr", 64'(instr0), 64'hD2824683);
    chk("b2b_ignored_busy", 64'(busy0), 64'd1);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("b2b_done", 64'(done0), 64'd1);
    chk("b2b_num", 64'(num0), 64'd1);
    chk("b2b_ready", 64'(req_ready0), 64'd1);
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("b2b_second_valid", 64'(instr_valid0), 64'd1);
    chk("b2b_second_instr", 64'(instr0), 64'hD2B579A7);
    @(negedge clk);
    instr_ready = 1'b0;
    chk("b2b_second_done", 64'(done0), 64'd1);
    chk("b2b_second_num", 64'(num0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
